// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and emits aligned stereo pairs.
// Optional left-justified framing is compiled in with `define I2S_RX_LJ_EN (adds the lj_mode input).
module i2s_rx #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    bclk,
    input  logic                    lrclk,
    input  logic                    sdata,
`ifdef I2S_RX_LJ_EN
    input  logic                    lj_mode,
`endif
    output logic [SAMPLE_WIDTH-1:0] sample_l,
    output logic [SAMPLE_WIDTH-1:0] sample_r,
    output logic                    sample_valid,
    output logic                    frame_error
);

    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] SLOT_CNT  = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} state_t;

    logic [SYNC_STAGES-1:0]  bclk_sync_q, lr_sync_q, sd_sync_q;
    logic                    bclk_prev_q, bit_q, lr_q, sd_q, lr_last_q;
    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, left_q, left_d;
    logic [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic                    valid_q, valid_d, error_q, error_d;
    logic                    lj_active, boundary, nb_event, short_word, word_done, overrun;
    logic [CW-1:0]           cap_last;

`ifdef I2S_RX_LJ_EN
    logic lj_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                lj_q <= 1'b0;
        else if (state_q == IDLE) lj_q <= lj_mode;
    end
    assign lj_active = lj_q;
`else
    assign lj_active = 1'b0;
`endif

    // Synchronise, detect bclk rise, then register the event with its lrclk/sdata so all three stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            bit_q       <= 1'b0;
            lr_q        <= 1'b0;
            sd_q        <= 1'b0;
            lr_last_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sdata};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
            bit_q       <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
            lr_q        <= lr_sync_q[SYNC_STAGES-1];
            sd_q        <= sd_sync_q[SYNC_STAGES-1];
            if (bit_q) lr_last_q <= lr_q;
        end
    end

    // count_q is bit events since the boundary; in LJ mode the boundary bit is already word bit 0.
    assign cap_last   = lj_active ? CW'(SAMPLE_WIDTH - 2) : CW'(SAMPLE_WIDTH - 1);
    assign boundary   = bit_q && (lr_q != lr_last_q);
    assign nb_event   = bit_q && !boundary;
    assign short_word = boundary && (count_q <= cap_last);
    assign word_done  = nb_event && (count_q == cap_last);
    assign overrun    = nb_event && (count_q == SLOT_LAST);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        left_d     = left_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        valid_d    = 1'b0;
        error_d    = error_q;

        if (boundary) begin
            count_d = '0;
            if (lj_active) shift_d = {shift_q[SAMPLE_WIDTH-2:0], sd_q};
        end else if (nb_event) begin
            if (count_q <= cap_last) shift_d = {shift_q[SAMPLE_WIDTH-2:0], sd_q};
            if (count_q != SLOT_CNT) count_d = count_q + CW'(1);
        end

        if (!enable) begin
            state_d = IDLE;
            error_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:  state_d = ALIGN;
                ALIGN: if (boundary && !lr_q) state_d = LEFT;
                LEFT: begin
                    if (short_word || overrun) begin
                        error_d = 1'b1;
                        state_d = ALIGN;
                    end else if (boundary && lr_q) begin
                        state_d = RIGHT;
                    end else if (word_done) begin
                        left_d = shift_d;
                    end
                end
                RIGHT: begin
                    if (short_word || overrun) begin
                        error_d = 1'b1;
                        state_d = ALIGN;
                    end else if (boundary) begin
                        state_d = LEFT;
                    end else if (word_done) begin
                        sample_l_d = left_q;
                        sample_r_d = shift_d;
                        valid_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            left_q     <= '0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign frame_error  = error_q;

endmodule
